macc_stream_pipe: RTL and testbench
===================================

// Module: macc_stream_pipe
// PURPOSE
//  Multi-channel pipelined multiply-accumulate over framed input streams. NUM_CH lanes share one valid/last
//  framing; each lane accumulates a*b over a frame and emits the sum when the frame ends. Next generation of
//  the single-lane free-running MAC: adds framing, signed mode, term count, and optional saturation.
//  Intended as a DSP-inference target in FPGA flow test designs.
// PARAMETERS
//  NUM_CH        4    number of independent lanes
//  INPUT_WIDTH   18   width of each a/b operand
//  OUTPUT_WIDTH  40   accumulator / result width per lane (>= 2*INPUT_WIDTH)
//  SIGNED        0    1: operands and accumulator two's complement; 0: unsigned
//  COUNT_WIDTH   16   width of frame term counter
// PORTS
//  clk        in   1                     sole clock, rising edge
//  reset      in   1                     synchronous, active-high
//  in_valid   in   1                     a/b/in_last valid this cycle
//  in_last    in   1                     final term of current frame
//  a          in   NUM_CH*INPUT_WIDTH    lane operands, lane i at [i*IW +: IW]
//  b          in   NUM_CH*INPUT_WIDTH    lane operands
//  out_valid  out  1                     one-cycle pulse: y/out_count/out_ovf hold a frame result
//  y          out  NUM_CH*OUTPUT_WIDTH   per-lane frame sums
//  out_count  out  COUNT_WIDTH           terms in the completed frame (saturates at all-ones)
//  out_ovf    out  NUM_CH                per-lane sticky overflow for the frame
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - No backpressure; every cycle with in_valid=1 is accepted.
//  - Stage 1 (edge 1): prod_reg <= a*b (2*IW bits, signed/unsigned per SIGNED); v1 <= in_valid; l1 <= in_last.
//  - Stage 2 (edge 2), if v1: sum = (start ? 0 : acc) + ext(prod_reg), extended to OW (sign-extend iff SIGNED).
//    acc <= sum; cnt <= start ? 1 : sat_inc(cnt); start <= l1.
//    If l1: y <= sum, out_count <= new cnt, out_ovf <= new ovf, out_valid <= 1. Else out_valid <= 0.
//  - Latency: in_valid&in_last at cycle N -> out_valid high in cycle N+2.
//  - Gaps (in_valid=0) mid-frame: acc/cnt hold; stage registers pass bubbles.
//  - Back-to-back frames: last at N, first of next at N+1 -> new frame starts from 0, no lost cycle.
//  - Single-term frame (first and last together) valid: result = a*b, count = 1.
//  - y/out_count/out_ovf hold between pulses.
//  - Reset: all pipeline regs, acc, cnt, y, out_count, out_ovf = 0; out_valid = 0; start = 1.
//    Reset mid-frame discards partial sums and in-flight stages; no out_valid is produced for them.
//  - Counter: increments to 2^COUNT_WIDTH-1, then holds.
// CONFIGURATION
//  MACC_STREAM_SATURATE_EN defined:
//    On overflow of sum, clamp to max/min representable (signed: +2^(OW-1)-1 / -2^(OW-1); unsigned: 2^OW-1).
//    Set lane ovf (sticky until the next frame start).
//  Not defined:
//    Accumulator wraps modulo 2^OW. out_ovf is driven constant 0.
// STRUCTURE
//  - Package macc_stream_pkg: lane-slicing helper constants, SAT_MAX/SAT_MIN per SIGNED/OW, and the
//    count-saturation constant.
//  - Sub-module macc_stream_lane: per-lane prod_reg, acc, ovf, y slice, instantiated NUM_CH times via generate.
//  - Top level owns shared framing: v1, l1, start, cnt, out_valid, out_count.
// TESTING
//  1. Unsigned, 3-term frame, lane0 a,b = (2,3),(4,5),(6,7) -> out_valid 2 cycles after last; y0=68, count=3.
//  2. SIGNED=1, lane1 terms (-3,4),(5,-2) -> y1 = -22 sign-correct in OW bits; other lanes independent.
//  3. Back-to-back frames [1*1, last] then [2*2, last] -> two consecutive out_valid pulses;
//     y0 = 1 then 4; no carry-over.
//  4. Bubbles: valid terms separated by 3 idle cycles -> same sum as gapless; out_valid only after last.
//  5. Reset asserted one cycle after last -> no out_valid; all outputs 0; next frame 7*8 -> y0 = 56.
//  6. OW=36, unsigned, max*max twice: with MACC_STREAM_SATURATE_EN -> y0 = 2^36-1, ovf0 = 1;
//     without -> wrapped value, ovf0 = 0.

Source files
------------

// File: rtl/macc_stream_pkg.sv
// Shared constants and helpers for macc_stream_pipe.
// Build option: define MACC_STREAM_SATURATE_EN to clamp lane sums and report
// overflow. Without it, the lane sums wrap.
// Contents:
//   *_DEF            default parameter values for the top level
//   lane_lsb()       bit offset of a lane inside a flattened lane bus
//   sat_max/sat_min  clamp limits for a given result width and signedness
//   cnt_max()        all-ones value of the frame term counter
package macc_stream_pkg;

    localparam int unsigned NUM_CH_DEF       = 4;
    localparam int unsigned INPUT_WIDTH_DEF  = 18;
    localparam int unsigned OUTPUT_WIDTH_DEF = 40;
    localparam int unsigned SIGNED_DEF       = 0;
    localparam int unsigned COUNT_WIDTH_DEF  = 16;

    // Widest constant the helpers can produce; callers truncate with a cast.
    localparam int unsigned CONST_FN_W = 256;

    // Bit offset of lane 'lane' in a bus of 'width'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Value with bits [n-1:0] set.
    function automatic logic [CONST_FN_W-1:0] ones_below(input int unsigned n);
        logic [CONST_FN_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CONST_FN_W; i++) begin
            m[i] = 1'(i < n);
        end
        return m;
    endfunction

    // Largest representable result: 2^(ow-1)-1 signed, 2^ow-1 unsigned.
    function automatic logic [CONST_FN_W-1:0] sat_max(input int unsigned ow, input bit sgn);
        return ones_below(sgn ? ow - 1 : ow);
    endfunction

    // Smallest representable result: -2^(ow-1) signed, 0 unsigned.
    function automatic logic [CONST_FN_W-1:0] sat_min(input int unsigned ow, input bit sgn);
        logic [CONST_FN_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CONST_FN_W; i++) begin
            m[i] = 1'(sgn && (i + 1 == ow));
        end
        return m;
    endfunction

    // Term counter ceiling.
    function automatic logic [CONST_FN_W-1:0] cnt_max(input int unsigned cw);
        return ones_below(cw);
    endfunction

endpackage

// File: rtl/macc_stream_pipe_lane.sv
// One multiply-accumulate lane of macc_stream_pipe.
// Build option: MACC_STREAM_SATURATE_EN enables clamping and the sticky
// per-frame overflow flag; otherwise the accumulator wraps and ovf_o is 0.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   a_i, b_i        lane operands (stage 1 input)
//   v1_i, l1_i      stage-2 valid / last, shared framing from the top
//   start_i         current stage-2 term is the first of its frame
//   y_o             registered frame sum, updated on the frame's last term
//   ovf_o           registered overflow flag for the frame held in y_o
module macc_stream_pipe_lane
    import macc_stream_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = INPUT_WIDTH_DEF,
    parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int unsigned SIGNED       = SIGNED_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INPUT_WIDTH-1:0]  a_i,
    input  logic [INPUT_WIDTH-1:0]  b_i,
    input  logic                    v1_i,
    input  logic                    l1_i,
    input  logic                    start_i,
    output logic [OUTPUT_WIDTH-1:0] y_o,
    output logic                    ovf_o
);

    localparam int unsigned PW  = 2 * INPUT_WIDTH;
    localparam bit          SGN = (SIGNED != 0);

    logic [PW-1:0]           a_ext;
    logic [PW-1:0]           b_ext;
    logic [PW-1:0]           prod_d;
    logic [PW-1:0]           prod_q;
    logic [OUTPUT_WIDTH-1:0] prod_ext;
    logic [OUTPUT_WIDTH-1:0] base;
    logic [OUTPUT_WIDTH-1:0] sum;
    logic [OUTPUT_WIDTH-1:0] acc_d;
    logic [OUTPUT_WIDTH-1:0] acc_q;
    logic [OUTPUT_WIDTH-1:0] y_d;
    logic [OUTPUT_WIDTH-1:0] y_q;

    // Operand extension to product width; the low PW bits of the product are
    // the same for signed and unsigned once operands are extended correctly.
    always_comb begin
        if (SGN) begin
            a_ext    = PW'($signed(a_i));
            b_ext    = PW'($signed(b_i));
            prod_ext = OUTPUT_WIDTH'($signed(prod_q));
        end else begin
            a_ext    = PW'(a_i);
            b_ext    = PW'(b_i);
            prod_ext = OUTPUT_WIDTH'(prod_q);
        end
        prod_d = a_ext * b_ext;
        base   = start_i ? '0 : acc_q;
    end

`ifdef MACC_STREAM_SATURATE_EN
    localparam int unsigned             SW      = OUTPUT_WIDTH + 1;
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX = OUTPUT_WIDTH'(sat_max(OUTPUT_WIDTH, SGN));
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN = OUTPUT_WIDTH'(sat_min(OUTPUT_WIDTH, SGN));

    logic [SW-1:0] sum_w;
    logic          ovf_now;
    logic          ovf_new;
    logic          ovf_d;
    logic          ovf_q;
    logic          ovf_out_d;
    logic          ovf_out_q;

    // One guard bit exposes overflow; clamp toward the side it left from.
    always_comb begin
        if (SGN) begin
            sum_w   = SW'($signed(base)) + SW'($signed(prod_ext));
            ovf_now = sum_w[OUTPUT_WIDTH] ^ sum_w[OUTPUT_WIDTH-1];
        end else begin
            sum_w   = SW'(base) + SW'(prod_ext);
            ovf_now = sum_w[OUTPUT_WIDTH];
        end
        if (ovf_now) begin
            sum = (SGN && sum_w[OUTPUT_WIDTH]) ? SAT_MIN : SAT_MAX;
        end else begin
            sum = sum_w[OUTPUT_WIDTH-1:0];
        end
        ovf_new   = (start_i ? 1'b0 : ovf_q) | ovf_now;
        ovf_d     = v1_i ? ovf_new : ovf_q;
        ovf_out_d = (v1_i && l1_i) ? ovf_new : ovf_out_q;
    end

    // Sticky overflow state for the running frame and the reported frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign ovf_o = ovf_out_q;
`else
    // Modulo-2^OW accumulation.
    always_comb begin
        sum = base + prod_ext;
    end

    assign ovf_o = 1'b0;
`endif

    // Accumulate on valid terms; publish the sum on the frame's last term.
    always_comb begin
        acc_d = acc_q;
        y_d   = y_q;
        if (v1_i) begin
            acc_d = sum;
            if (l1_i) begin
                y_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
            y_q    <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            y_q    <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/macc_stream_pipe.sv
// Multi-lane framed multiply-accumulate. NUM_CH lanes share one valid/last
// framing; each lane sums a*b over a frame and reports the sum two cycles
// after the frame's last term.
// Build option: MACC_STREAM_SATURATE_EN (clamp sums, sticky per-lane
// overflow). Undefined: sums wrap modulo 2^OUTPUT_WIDTH and out_ovf is 0.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   in_valid        a/b/in_last valid this cycle (always accepted)
//   in_last         final term of the current frame
//   a, b            lane operands, lane i at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   out_valid       one-cycle pulse: y/out_count/out_ovf hold a new result
//   y               per-lane frame sums, lane i at [i*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   out_count       terms in the completed frame, saturating at all-ones
//   out_ovf         per-lane overflow for the completed frame
module macc_stream_pipe
    import macc_stream_pkg::*;
#(
    parameter int unsigned NUM_CH       = NUM_CH_DEF,
    parameter int unsigned INPUT_WIDTH  = INPUT_WIDTH_DEF,
    parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int unsigned SIGNED       = SIGNED_DEF,
    parameter int unsigned COUNT_WIDTH  = COUNT_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [NUM_CH*INPUT_WIDTH-1:0]  a,
    input  logic [NUM_CH*INPUT_WIDTH-1:0]  b,
    output logic                           out_valid,
    output logic [NUM_CH*OUTPUT_WIDTH-1:0] y,
    output logic [COUNT_WIDTH-1:0]         out_count,
    output logic [NUM_CH-1:0]              out_ovf
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(cnt_max(COUNT_WIDTH));

    logic                   v1_q;
    logic                   l1_q;
    logic                   start_d;
    logic                   start_q;
    logic [COUNT_WIDTH-1:0] cnt_next;
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   out_valid_d;
    logic                   out_valid_q;
    logic [COUNT_WIDTH-1:0] out_count_d;
    logic [COUNT_WIDTH-1:0] out_count_q;

    // Shared frame bookkeeping for the stage-2 term.
    always_comb begin
        start_d     = start_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;
        if (start_q) begin
            cnt_next = COUNT_WIDTH'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + COUNT_WIDTH'(1);
        end
        if (v1_q) begin
            cnt_d   = cnt_next;
            start_d = l1_q;
            if (l1_q) begin
                out_valid_d = 1'b1;
                out_count_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            start_q     <= 1'b1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            v1_q        <= in_valid;
            l1_q        <= in_last;
            start_q     <= start_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        localparam int unsigned LSB_IN  = lane_lsb(i, INPUT_WIDTH);
        localparam int unsigned LSB_OUT = lane_lsb(i, OUTPUT_WIDTH);

        macc_stream_pipe_lane #(
            .INPUT_WIDTH  (INPUT_WIDTH),
            .OUTPUT_WIDTH (OUTPUT_WIDTH),
            .SIGNED       (SIGNED)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .a_i     (a[LSB_IN +: INPUT_WIDTH]),
            .b_i     (b[LSB_IN +: INPUT_WIDTH]),
            .v1_i    (v1_q),
            .l1_i    (l1_q),
            .start_i (start_q),
            .y_o     (y[LSB_OUT +: OUTPUT_WIDTH]),
            .ovf_o   (out_ovf[i])
        );
    end

endmodule

// File: tb/tb_macc_stream_pipe.sv
// Bench for macc_stream_pipe: three instances (unsigned OW=40, signed OW=40,
// unsigned OW=36) share one stimulus stream; expected frame results come
// from exact-integer arithmetic on the accepted terms.
module tb_macc_stream_pipe;

    localparam int unsigned NC = 4;
    localparam int unsigned IW = 18;
    localparam int unsigned CW = 16;
    localparam int unsigned ND = 3;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_last;
    logic [NC-1:0][IW-1:0]   a;
    logic [NC-1:0][IW-1:0]   b;

    logic                    ov0, ov1, ov2;
    logic [NC*40-1:0]        y0, y1;
    logic [NC*36-1:0]        y2;
    logic [CW-1:0]           cnt0, cnt1, cnt2;
    logic [NC-1:0]           ovf0, ovf1, ovf2;

    macc_stream_pipe #(.NUM_CH(NC), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(40), .SIGNED(0), .COUNT_WIDTH(CW)) u_dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .a(a), .b(b),
        .out_valid(ov0), .y(y0), .out_count(cnt0), .out_ovf(ovf0));

    macc_stream_pipe #(.NUM_CH(NC), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(40), .SIGNED(1), .COUNT_WIDTH(CW)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .a(a), .b(b),
        .out_valid(ov1), .y(y1), .out_count(cnt1), .out_ovf(ovf1));

    macc_stream_pipe #(.NUM_CH(NC), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(36), .SIGNED(0), .COUNT_WIDTH(CW)) u_dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .a(a), .b(b),
        .out_valid(ov2), .y(y2), .out_count(cnt2), .out_ovf(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]                    due;
        logic [CW-1:0]                  cnt;
        logic [ND-1:0][NC-1:0]          ovf;
        logic [ND-1:0][NC-1:0][39:0]    y;
    } exp_t;

    int            errors;
    int            checks;
    int unsigned   cyc;
    bit            full_chk;
    exp_t          q[$];
    exp_t          hold;

    logic signed [127:0] acc_m [ND][NC];
    logic                ovf_m [ND][NC];
    int unsigned         n_m;
    bit                  start_m;

    function automatic int unsigned ow_of(input int d);
        return (d == 2) ? 36 : 40;
    endfunction

    function automatic bit sgn_of(input int d);
        return d == 1;
    endfunction

    function automatic logic [NC-1:0][IW-1:0] rnd_vec();
        logic [NC-1:0][IW-1:0] v;
        for (int l = 0; l < NC; l++) v[l] = IW'($urandom);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hold    = '0;
        n_m     = 0;
        start_m = 1'b1;
        for (int d = 0; d < ND; d++)
            for (int l = 0; l < NC; l++) begin
                acc_m[d][l] = '0;
                ovf_m[d][l] = 1'b0;
            end
    endtask

    // Exact sum of products per lane; clamps at the representable range when
    // saturation is built in, otherwise the reported value is the sum mod 2^OW.
    task automatic model_accept(input logic [NC-1:0][IW-1:0] av, input logic [NC-1:0][IW-1:0] bv,
                                input logic lst);
        logic signed [127:0] p;
        logic signed [127:0] s;
        exp_t e;
`ifdef MACC_STREAM_SATURATE_EN
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        logic signed [127:0] one;
        one = 128'sd1;
`endif
        for (int d = 0; d < ND; d++) begin
            for (int l = 0; l < NC; l++) begin
                if (sgn_of(d)) p = 128'($signed(av[l])) * 128'($signed(bv[l]));
                else           p = 128'(av[l]) * 128'(bv[l]);
                if (start_m) begin
                    acc_m[d][l] = '0;
                    ovf_m[d][l] = 1'b0;
                end
                s = acc_m[d][l] + p;
`ifdef MACC_STREAM_SATURATE_EN
                if (sgn_of(d)) begin
                    hi = (one <<< (ow_of(d) - 1)) - one;
                    lo = -(one <<< (ow_of(d) - 1));
                end else begin
                    hi = (one <<< ow_of(d)) - one;
                    lo = '0;
                end
                if (s > hi) begin
                    s = hi;
                    ovf_m[d][l] = 1'b1;
                end else if (s < lo) begin
                    s = lo;
                    ovf_m[d][l] = 1'b1;
                end
`endif
                acc_m[d][l] = s;
            end
        end
        if (start_m)            n_m = 1;
        else if (n_m < 65535)   n_m = n_m + 1;
        start_m = lst;
        if (lst) begin
            e     = '0;
            e.due = cyc + 2;
            e.cnt = CW'(n_m);
            for (int d = 0; d < ND; d++)
                for (int l = 0; l < NC; l++) begin
                    e.y[d][l]   = 40'(acc_m[d][l]);
                    e.ovf[d][l] = ovf_m[d][l];
                end
            q.push_back(e);
        end
    endtask

    task automatic check_vals();
        for (int l = 0; l < NC; l++) begin
            chk($sformatf("y_u_l%0d", l), 64'(y0[l*40 +: 40]), 64'(hold.y[0][l]));
            chk($sformatf("y_s_l%0d", l), 64'(y1[l*40 +: 40]), 64'(hold.y[1][l]));
            chk($sformatf("y_n_l%0d", l), 64'(y2[l*36 +: 36]), 64'(hold.y[2][l][35:0]));
        end
        chk("cnt_u", 64'(cnt0), 64'(hold.cnt));
        chk("cnt_s", 64'(cnt1), 64'(hold.cnt));
        chk("cnt_n", 64'(cnt2), 64'(hold.cnt));
        chk("ovf_u", 64'(ovf0), 64'(hold.ovf[0]));
        chk("ovf_s", 64'(ovf1), 64'(hold.ovf[1]));
        chk("ovf_n", 64'(ovf2), 64'(hold.ovf[2]));
    endtask

    task automatic step();
        logic expv;
        @(posedge clk);
        cyc++;
        #1;
        expv = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            hold = q.pop_front();
            expv = 1'b1;
        end
        chk("out_valid_u", 64'(ov0), 64'(expv));
        chk("out_valid_s", 64'(ov1), 64'(expv));
        chk("out_valid_n", 64'(ov2), 64'(expv));
        if (full_chk || expv) check_vals();
    endtask

    task automatic term(input logic [NC-1:0][IW-1:0] av, input logic [NC-1:0][IW-1:0] bv,
                        input logic lst);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        in_last  = lst;
        model_accept(av, bv, lst);
        step();
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        a        = rnd_vec();
        b        = rnd_vec();
        repeat (n) step();
    endtask

    task automatic do_reset(input int unsigned n);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_reset();
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        logic [NC-1:0][IW-1:0] av;
        logic [NC-1:0][IW-1:0] bv;
        int unsigned len;

        errors   = 0;
        checks   = 0;
        cyc      = 0;
        full_chk = 1'b1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = '0;
        b        = '0;

        // Reset state
        do_reset(2);
        idle(1);

        // Three-term unsigned frame on lane 0: 6+20+42
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd2; bv[0] = 18'd3; term(av, bv, 1'b0);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd4; bv[0] = 18'd5; term(av, bv, 1'b0);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd6; bv[0] = 18'd7; term(av, bv, 1'b1);
        chk("t1_early", 64'(ov0), 64'd0);
        idle(1);
        chk("t1_valid", 64'(ov0), 64'd1);
        chk("t1_y0", 64'(y0[39:0]), 64'd68);
        chk("t1_cnt", 64'(cnt0), 64'd3);
        idle(2);

        // Signed lane 1: (-3*4)+(5*-2) = -22
        av = rnd_vec(); bv = rnd_vec(); av[1] = 18'h3FFFD; bv[1] = 18'd4;     term(av, bv, 1'b0);
        av = rnd_vec(); bv = rnd_vec(); av[1] = 18'd5;     bv[1] = 18'h3FFFE; term(av, bv, 1'b1);
        idle(1);
        chk("t2_y1", 64'(y1[79:40]), 64'h00FF_FFFF_FFEA);
        idle(1);

        // Back-to-back single-term frames
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd1; bv[0] = 18'd1; term(av, bv, 1'b1);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd2; bv[0] = 18'd2; term(av, bv, 1'b1);
        chk("t3_valid_a", 64'(ov0), 64'd1);
        chk("t3_y0_a", 64'(y0[39:0]), 64'd1);
        idle(1);
        chk("t3_valid_b", 64'(ov0), 64'd1);
        chk("t3_y0_b", 64'(y0[39:0]), 64'd4);
        chk("t3_cnt_b", 64'(cnt0), 64'd1);
        idle(2);

        // Bubbles between terms: 15+77+221
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd3;  bv[0] = 18'd5;  term(av, bv, 1'b0); idle(3);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd7;  bv[0] = 18'd11; term(av, bv, 1'b0); idle(3);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd13; bv[0] = 18'd17; term(av, bv, 1'b1);
        idle(1);
        chk("t4_y0", 64'(y0[39:0]), 64'd313);
        chk("t4_cnt", 64'(cnt0), 64'd3);
        idle(2);

        // Reset one cycle after last discards the frame
        term(rnd_vec(), rnd_vec(), 1'b0);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd9; bv[0] = 18'd9; term(av, bv, 1'b1);
        do_reset(1);
        chk("t5_noval", 64'(ov0), 64'd0);
        chk("t5_y0_zero", 64'(y0[39:0]), 64'd0);
        chk("t5_cnt_zero", 64'(cnt0), 64'd0);
        idle(2);
        av = rnd_vec(); bv = rnd_vec(); av[0] = 18'd7; bv[0] = 18'd8; term(av, bv, 1'b1);
        idle(1);
        chk("t5_y0", 64'(y0[39:0]), 64'd56);
        chk("t5_cnt", 64'(cnt0), 64'd1);
        idle(2);

        // max*max twice into a 36-bit accumulator
        av = '1; bv = '1; term(av, bv, 1'b0); term(av, bv, 1'b1);
        idle(1);
`ifdef MACC_STREAM_SATURATE_EN
        chk("t6_y_n0", 64'(y2[35:0]), 64'h0_000F_FFFF_FFFF);
        chk("t6_ovf_n0", 64'(ovf2[0]), 64'd1);
`else
        chk("t6_y_n0", 64'(y2[35:0]), 64'h0_000F_FFF0_0002);
        chk("t6_ovf_n0", 64'(ovf2[0]), 64'd0);
`endif
        chk("t6_y_s0", 64'(y1[39:0]), 64'd2);
        idle(2);

        // Random frames with random gaps
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 6);
            for (int unsigned k = 0; k < len; k++) begin
                term(rnd_vec(), rnd_vec(), 1'(k == len - 1));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(3);

        // Term counter saturation over a very long frame
        full_chk = 1'b0;
        for (int k = 0; k < 65537; k++) begin
            term(rnd_vec(), rnd_vec(), 1'(k == 65536));
        end
        full_chk = 1'b1;
        idle(1);
        chk("t8_cnt_sat", 64'(cnt0), 64'hFFFF);
        idle(2);

        // Short frame after saturation restarts the count
        term(rnd_vec(), rnd_vec(), 1'b0);
        term(rnd_vec(), rnd_vec(), 1'b1);
        idle(1);
        chk("t9_cnt", 64'(cnt0), 64'd2);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
